// File: rtl/mips_multicycle_control_if.sv
// mips_multicycle_control_if
//   Signal bundle between the multi-cycle MIPS sequencer and its datapath and
//   shared instruction/data memory.
//
//   master modport : the sequencer (samples OPCODE/FUNC/zero/mem_ready,
//                    drives every control output and the debug state)
//   slave modport  : the datapath/memory side (the mirror image)
//
//   Memory handshake: the sequencer holds its request (memread level, iord,
//   address mux) steady for as many cycles as needed; the memory raises
//   mem_ready in the cycle the read data is valid or the write is accepted.
//   The transfer completes on the rising edge where the sequencer is in a
//   memory state and mem_ready=1. Strobes that commit state (irwrite, pcen in
//   FETCH, memwrite) are asserted only in that completing cycle.
interface mips_multicycle_control_if;
    logic [5:0] OPCODE;
    logic [5:0] FUNC;
    logic       zero;
    logic       mem_ready;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       branch;
    logic       iord;
    logic       irwrite;
    logic [1:0] memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regdist;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] ALU_SELECTION;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  OPCODE, FUNC, zero, mem_ready,
        output pcen, pcsrc, branch, iord, irwrite, memread, memwrite,
               memtoreg, regdist, regwrite, alusrca, alusrcb,
               ALU_SELECTION, illegal, state
    );

    modport slave (
        output OPCODE, FUNC, zero, mem_ready,
        input  pcen, pcsrc, branch, iord, irwrite, memread, memwrite,
               memtoreg, regdist, regwrite, alusrca, alusrcb,
               ALU_SELECTION, illegal, state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Multi-cycle control sequencer for a MIPS datapath. Each instruction walks
//   FETCH -> DECODE -> (execute / memory) -> writeback and back to FETCH.
//   Outputs are a Moore decode of the state, except:
//     - pcen/irwrite (FETCH) and memwrite (MEMWR) are gated by mem_ready,
//     - pcen in BRANCH follows the ALU zero flag,
//     - ALU_SELECTION in RTEXE/IMMEXE comes from FUNC/OPCODE.
//
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high; while high every output reads 0
//     bus   : mips_multicycle_control_if.master (IR fields, zero flag,
//             memory ready in; all control strobes and debug state out)
//
//   Build option: MC_HALF_LOAD_EN enables LH (100001) / LHU (100101).
//   Without it both opcodes are reported illegal in DECODE and memread
//   only ever takes the values 0 or 1.
module mips_multicycle_control (
    input  logic                        clk,
    input  logic                        reset,
    mips_multicycle_control_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEXE = 4'd9,
        S_IMMWB  = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_HALF_LOAD_EN
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;
`endif
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_SLL  = 3'd2;
    localparam logic [2:0] ALU_SRL  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_SLT  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    state_t state_q, state_d;

    // R-type FUNC decode.
    logic       func_ok;
    logic [2:0] func_alu;
    always_comb begin
        func_ok  = 1'b1;
        func_alu = ALU_ADD;
        case (bus.FUNC)
            6'b100000: func_alu = ALU_ADD;
            6'b100010: func_alu = ALU_SUB;
            6'b000000: func_alu = ALU_SLL;
            6'b000010: func_alu = ALU_SRL;
            6'b100100: func_alu = ALU_AND;
            6'b100101: func_alu = ALU_OR;
            6'b101010: func_alu = ALU_SLT;
            6'b101011: func_alu = ALU_SLTU;
            default:   func_ok  = 1'b0;
        endcase
    end

    // Memory-class opcodes and the memread size code they request.
    logic       is_mem;
    logic [1:0] mem_size;
    always_comb begin
        is_mem   = 1'b0;
        mem_size = 2'd1;
        case (bus.OPCODE)
            OP_LW:  is_mem = 1'b1;
            OP_SW:  is_mem = 1'b1;
`ifdef MC_HALF_LOAD_EN
            OP_LH:  begin is_mem = 1'b1; mem_size = 2'd2; end
            OP_LHU: begin is_mem = 1'b1; mem_size = 2'd3; end
`endif
            default: ;
        endcase
    end

    // Immediate-ALU opcodes.
    logic       is_imm;
    logic [2:0] imm_alu;
    always_comb begin
        is_imm  = 1'b1;
        imm_alu = ALU_ADD;
        case (bus.OPCODE)
            OP_ADDI: imm_alu = ALU_ADD;
            OP_ANDI: imm_alu = ALU_AND;
            OP_ORI:  imm_alu = ALU_OR;
            default: is_imm  = 1'b0;
        endcase
    end

    // Ungated (pre-reset) control values.
    logic       pcwrite_c;
    logic       branch_c;
    logic [1:0] pcsrc_c;
    logic       iord_c;
    logic       irwrite_c;
    logic [1:0] memread_c;
    logic       memwrite_c;
    logic       memtoreg_c;
    logic       regdist_c;
    logic       regwrite_c;
    logic       alusrca_c;
    logic [1:0] alusrcb_c;
    logic [2:0] alu_c;
    logic       illegal_c;
    logic       pcen_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        pcsrc_c    = 2'd0;
        iord_c     = 1'b0;
        irwrite_c  = 1'b0;
        memread_c  = 2'd0;
        memwrite_c = 1'b0;
        memtoreg_c = 1'b0;
        regdist_c  = 1'b0;
        regwrite_c = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = 2'd0;
        alu_c      = ALU_ADD;
        illegal_c  = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every fetch cycle but only committed,
                // together with the IR load, when memory returns the word.
                memread_c = 2'd1;
                alusrcb_c = 2'd1;
                pcwrite_c = bus.mem_ready;
                irwrite_c = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut.
                alusrcb_c = 2'd3;
                if (bus.OPCODE == OP_RTYPE && func_ok) state_d = S_RTEXE;
                else if (is_mem)                       state_d = S_MEMADR;
                else if (bus.OPCODE == OP_BEQ)         state_d = S_BRANCH;
                else if (is_imm)                       state_d = S_IMMEXE;
                else begin
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'd2;
                state_d   = (bus.OPCODE == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord_c    = 1'b1;
                memread_c = mem_size;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = bus.mem_ready;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_RTEXE: begin
                alusrca_c = 1'b1;
                alu_c     = func_alu;
                state_d   = S_RTWB;
            end
            S_RTWB: begin
                regdist_c  = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_c = 1'b1;
                alu_c     = ALU_SUB;
                branch_c  = 1'b1;
                pcsrc_c   = 2'd1;
                state_d   = S_FETCH;
            end
            S_IMMEXE: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'd2;
                alu_c     = imm_alu;
                state_d   = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Unused encodings: recover to FETCH with everything idle.
                state_d = S_FETCH;
            end
        endcase
    end

    assign pcen_c = pcwrite_c | (branch_c & bus.zero);

    // Reset masks every output combinationally so an aborted instruction
    // cannot write anything even in the cycle reset first appears.
    assign bus.pcen          = reset ? 1'b0 : pcen_c;
    assign bus.pcsrc         = reset ? 2'd0 : pcsrc_c;
    assign bus.branch        = reset ? 1'b0 : branch_c;
    assign bus.iord          = reset ? 1'b0 : iord_c;
    assign bus.irwrite       = reset ? 1'b0 : irwrite_c;
    assign bus.memread       = reset ? 2'd0 : memread_c;
    assign bus.memwrite      = reset ? 1'b0 : memwrite_c;
    assign bus.memtoreg      = reset ? 1'b0 : memtoreg_c;
    assign bus.regdist       = reset ? 1'b0 : regdist_c;
    assign bus.regwrite      = reset ? 1'b0 : regwrite_c;
    assign bus.alusrca       = reset ? 1'b0 : alusrca_c;
    assign bus.alusrcb       = reset ? 2'd0 : alusrcb_c;
    assign bus.ALU_SELECTION = reset ? 3'd0 : alu_c;
    assign bus.illegal       = reset ? 1'b0 : illegal_c;
    assign bus.state         = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
//   Drives instructions cycle by cycle; for each cycle the reference model
//   pushes the full expected output vector into exp_q, and a negedge monitor
//   pops and compares it with what the sequencer presents.
module tb_mips_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       branch;
        logic       iord;
        logic       irwrite;
        logic [1:0] memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regdist;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alu;
        logic       illegal;
    } rec_t;

    localparam int W = $bits(rec_t);

    logic clk;
    logic reset;
    mips_multicycle_control_if bus ();

    mips_multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           total_cnt = 0;
    int           pass_cnt  = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t  a;
            rec_t  e;
            string nm;
            e  = rec_t'(exp_q.pop_front());
            nm = name_q.pop_front();
            a.st       = bus.state;
            a.pcen     = bus.pcen;
            a.pcsrc    = bus.pcsrc;
            a.branch   = bus.branch;
            a.iord     = bus.iord;
            a.irwrite  = bus.irwrite;
            a.memread  = bus.memread;
            a.memwrite = bus.memwrite;
            a.memtoreg = bus.memtoreg;
            a.regdist  = bus.regdist;
            a.regwrite = bus.regwrite;
            a.alusrca  = bus.alusrca;
            a.alusrcb  = bus.alusrcb;
            a.alu      = bus.ALU_SELECTION;
            a.illegal  = bus.illegal;
            total_cnt++;
            if (a === e) pass_cnt++;
            else $display("FAIL %s: got state=%0d vec=%h, expected state=%0d vec=%h",
                          nm, a.st, a, e.st, e);
        end
    end

    // ---------------- reference model ----------------
    function automatic rec_t mk(input int st);
        rec_t r;
        r    = '0;
        r.st = 4'(st);
        return r;
    endfunction

    function automatic bit half_en();
`ifdef MC_HALF_LOAD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // ALU code of each supported R-type FUNC; -1 when unsupported.
    function automatic int r_alu(input logic [5:0] fn);
        logic [5:0] tbl[8];
        tbl = '{6'b100000, 6'b100010, 6'b000000, 6'b000010,
                6'b100100, 6'b100101, 6'b101010, 6'b101011};
        for (int i = 0; i < 8; i++) if (tbl[i] == fn) return i;
        return -1;
    endfunction

    // memread size code for a load/store opcode; 0 when not a memory op.
    function automatic int mem_kind(input logic [5:0] op);
        if (op == 6'b100011 || op == 6'b101011) return 1;
        if (half_en() && op == 6'b100001) return 2;
        if (half_en() && op == 6'b100101) return 3;
        return 0;
    endfunction

    function automatic int imm_alu(input logic [5:0] op);
        if (op == 6'b001000) return 0;
        if (op == 6'b001100) return 4;
        if (op == 6'b001101) return 5;
        return -1;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input rec_t r, input logic mr, input logic z, input string nm);
        bus.mem_ready = mr;
        bus.zero      = z;
        exp_q.push_back(W'(r));
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int fw);
        rec_t r;
        r         = mk(0);
        r.memread = 2'd1;
        r.alusrcb = 2'd1;
        for (int i = 0; i < fw; i++) drive(r, 1'b0, 1'($urandom_range(0, 1)), "fetch_wait");
        r.irwrite = 1'b1;
        r.pcen    = 1'b1;
        drive(r, 1'b1, 1'($urandom_range(0, 1)), "fetch_done");
    endtask

    // One full instruction: fw fetch wait cycles, mw memory wait cycles,
    // z = zero flag in the BRANCH cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int fw, input int mw, input logic z);
        rec_t r;
        int   ra, mk_k, ia;
        bit   legal;
        bus.OPCODE = op;
        bus.FUNC   = fn;
        do_fetch(fw);
        ra    = r_alu(fn);
        mk_k  = mem_kind(op);
        ia    = imm_alu(op);
        legal = (op == 6'd0 && ra >= 0) || (mk_k != 0) || (op == 6'b000100) || (ia >= 0);
        r         = mk(1);
        r.alusrcb = 2'd3;
        r.illegal = !legal;
        drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "decode");
        if (!legal) return;
        if (op == 6'd0) begin
            r = mk(6); r.alusrca = 1'b1; r.alu = 3'(ra);
            drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rtexe");
            r = mk(7); r.regdist = 1'b1; r.regwrite = 1'b1;
            drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rtwb");
        end else if (mk_k != 0) begin
            r = mk(2); r.alusrca = 1'b1; r.alusrcb = 2'd2;
            drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "memadr");
            if (op == 6'b101011) begin
                r = mk(5); r.iord = 1'b1;
                for (int i = 0; i < mw; i++) drive(r, 1'b0, 1'($urandom_range(0, 1)), "memwr_wait");
                r.memwrite = 1'b1;
                drive(r, 1'b1, 1'($urandom_range(0, 1)), "memwr_done");
            end else begin
                r = mk(3); r.iord = 1'b1; r.memread = 2'(mk_k);
                for (int i = 0; i < mw; i++) drive(r, 1'b0, 1'($urandom_range(0, 1)), "memrd_wait");
                drive(r, 1'b1, 1'($urandom_range(0, 1)), "memrd_done");
                r = mk(4); r.memtoreg = 1'b1; r.regwrite = 1'b1;
                drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "memwb");
            end
        end else if (op == 6'b000100) begin
            r = mk(8); r.alusrca = 1'b1; r.alu = 3'd1; r.branch = 1'b1;
            r.pcsrc = 2'd1; r.pcen = z;
            drive(r, 1'($urandom_range(0, 1)), z, "branch");
        end else begin
            r = mk(9); r.alusrca = 1'b1; r.alusrcb = 2'd2; r.alu = 3'(ia);
            drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "immexe");
            r = mk(10); r.regwrite = 1'b1;
            drive(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "immwb");
        end
    endtask

    task automatic reset_cycles(input int n, input string nm);
        reset = 1'b1;
        for (int i = 0; i < n; i++) drive(mk(0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nm);
        reset = 1'b0;
    endtask

    // SW that is aborted by reset while waiting for memory in MEMWR.
    task automatic sw_abort();
        rec_t r;
        bus.OPCODE = 6'b101011;
        bus.FUNC   = 6'd0;
        do_fetch(0);
        r = mk(1); r.alusrcb = 2'd3;
        drive(r, 1'b1, 1'b0, "sw_decode");
        r = mk(2); r.alusrca = 1'b1; r.alusrcb = 2'd2;
        drive(r, 1'b1, 1'b0, "sw_memadr");
        r = mk(5); r.iord = 1'b1;
        drive(r, 1'b0, 1'b0, "sw_memwr_wait");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(mk(0), 1'b1, 1'b1, "reset_mid_memwr");
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] ops[9];
        logic [5:0] fns[8];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b100001, 6'b100101,
                6'b000100, 6'b001000, 6'b001100, 6'b001101};
        fns = '{6'b100000, 6'b100010, 6'b000000, 6'b000010,
                6'b100100, 6'b100101, 6'b101010, 6'b101011};
        reset         = 1'b1;
        bus.OPCODE    = 6'd0;
        bus.FUNC      = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_cycles(2, "reset_state");

        // Directed cases.
        sw_abort();
        run_instr(6'b000000, 6'b100000, 0, 0, 1'b0);   // ADD
        run_instr(6'b100011, 6'd0,      0, 2, 1'b0);   // LW, 2 wait cycles in MEMRD
        run_instr(6'b000100, 6'd0,      0, 0, 1'b1);   // BEQ taken
        run_instr(6'b000100, 6'd0,      0, 0, 1'b0);   // BEQ not taken
        run_instr(6'b001101, 6'd0,      0, 0, 1'b0);   // ORI
        run_instr(6'b111111, 6'd0,      0, 0, 1'b0);   // illegal opcode
        run_instr(6'b100101, 6'd0,      1, 1, 1'b0);   // LHU
        run_instr(6'b100001, 6'd0,      0, 0, 1'b0);   // LH
        run_instr(6'b000000, 6'b111111, 0, 0, 1'b0);   // illegal R-type FUNC
        run_instr(6'b101011, 6'd0,      2, 3, 1'b0);   // SW with waits

        // Randomized mix, occasionally interrupted by reset.
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 19) == 0) reset_cycles($urandom_range(1, 2), "rand_reset");
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
